// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the stack master and its bus interface.
// Holds the stack command encoding, the master FSM states and the default
// stack depth / data width used by stack_master.
package stack_pkg;

  localparam int DEPTH_DFLT  = 5;
  localparam int DATA_W_DFLT = 4;

  // Stack command encoding; the same values appear on the COMMAND bus.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_GET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } state_e;

endpackage

// File: rtl/stack_bus_if.sv
// stack_bus_if: tristate driver and negedge read-capture for the shared stack data bus.
// Ports: CLK/RESET; i_drive_en/i_drive_dat drive IO_DATA, otherwise high-Z;
//        i_cap_en samples IO_DATA on the falling edge into o_cap_dat; IO_DATA shared bus.
module stack_bus_if #(
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_drive_en,
  input  logic [DATA_W-1:0] i_drive_dat,
  input  logic              i_cap_en,
  output logic [DATA_W-1:0] o_cap_dat,
  inout  wire  [DATA_W-1:0] IO_DATA
);

  logic [DATA_W-1:0] r_cap_dat;

  assign IO_DATA   = i_drive_en ? i_drive_dat : {DATA_W{1'bz}};
  assign o_cap_dat = r_cap_dat;

  // The stack drives the bus from the rising edge that ends ISSUE, so the
  // falling edge in the middle of CAPTURE sees settled read data.
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET)
      r_cap_dat <= '0;
    else if (i_cap_en)
      r_cap_dat <= IO_DATA;
  end

endmodule

// File: rtl/stack_master.sv
// stack_master: turns single client requests (PUSH/POP/GET) into stack bus commands.
// Ports: CLK, RESET (async, active-high); req_* client request, rsp_* one-cycle response;
//        COMMAND/INDEX/IO_DATA stack bus; count = current occupancy.
// Optional: define STACK_MASTER_GET_EN to support GET; otherwise op 11 is rejected and INDEX is 0.
module stack_master
  import stack_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        req_index,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [1:0]        COMMAND,
  output logic [2:0]        INDEX,
  inout  wire  [DATA_W-1:0] IO_DATA,
  output logic [2:0]        count
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_e            r_state;
  op_e               r_op;
  op_e               r_cmd;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_count;
  logic              r_drive_en;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              w_err;
  logic              w_cap_en;
  logic [DATA_W-1:0] w_cap_dat;

  // Requests that cannot be served are rejected at accept time, before any
  // command reaches the stack.
  always_comb begin
    w_err = 1'b0;
    case (op_e'(req_op))
      OP_PUSH: w_err = (r_count == DEPTH_C);
      OP_POP:  w_err = (r_count == 3'd0);
`ifdef STACK_MASTER_GET_EN
      OP_GET:  w_err = (req_index >= r_count);
`else
      OP_GET:  w_err = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

`ifdef STACK_MASTER_GET_EN
  logic [2:0] r_index;
  assign INDEX = r_index;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_index <= 3'd0;
    else if (r_state == ST_IDLE && req_valid && !w_err)
      r_index <= req_index;
    else
      r_index <= 3'd0;
  end
`else
  logic w_unused_index;
  assign w_unused_index = ^req_index;
  assign INDEX          = 3'd0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_IDLE;
      r_cmd       <= OP_IDLE;
      r_data      <= '0;
      r_count     <= 3'd0;
      r_drive_en  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op   <= op_e'(req_op);
            r_data <= req_data;
            if (w_err) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
            end else begin
              r_state    <= ST_ISSUE;
              r_cmd      <= op_e'(req_op);
              r_drive_en <= (op_e'(req_op) == OP_PUSH);
            end
          end
        end
        ST_ISSUE: begin
          r_cmd      <= OP_IDLE;
          r_drive_en <= 1'b0;
          case (r_op)
            OP_PUSH: r_count <= r_count + 3'd1;
            OP_POP:  r_count <= r_count - 3'd1;
            default: r_count <= r_count;
          endcase
          if (r_op == OP_PUSH) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
          end else begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= w_cap_dat;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_cap_en  = (r_state == ST_CAPTURE);
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign COMMAND   = r_cmd;
  assign count     = r_count;

  stack_bus_if #(.DATA_W(DATA_W)) u_bus (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_drive_en  (r_drive_en),
    .i_drive_dat (r_data),
    .i_cap_en    (w_cap_en),
    .o_cap_dat   (w_cap_dat),
    .IO_DATA     (IO_DATA)
  );

endmodule
